// File: rtl/sram_pkg.sv
// Shared constants for the SRAM request arbiter: default widths, FSM encodings
// and the word returned to a requester whose read was aborted.
package sram_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam logic [15:0] ABORT_WORD = 16'hDEAD;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE   = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_WAIT_WR = 3'd3;
  localparam logic [2:0] ST_WAIT_RD = 3'd4;
  localparam logic [2:0] ST_GAP     = 3'd5;

endpackage

// File: rtl/sram_req_arbiter.sv
// Two-port round-robin front end for a single sram_controller: one strobe in
// flight at a time, completion via busy/valid, per-transaction timeout.
module sram_req_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TMO_CYC = 255,
  parameter int GAP_CYC = 2
) (
  input  logic              clk_50,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  output logic              ctl_wr,
  output logic              ctl_rd,
  input  logic [DATA_W-1:0] ctl_rdata,
  input  logic              ctl_valid,
  input  logic              ctl_busy,
  output logic              owner,
  output logic              tmo_err
);

  localparam logic [7:0] TMO_LIM  = 8'(TMO_CYC);
  localparam logic [2:0] GAP_LAST = 3'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  logic [2:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              tmo_q, tmo_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic [2:0]        gap_cnt_q, gap_cnt_d;

  logic              grant_port;
  logic              done;
  logic              abort;
  logic [DATA_W-1:0] ret_data;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wr_d         = 1'b0;
    rd_d         = 1'b0;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    tmo_d        = tmo_q;
    tmo_cnt_d    = tmo_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    done         = 1'b0;
    abort        = 1'b0;
    ret_data     = ctl_rdata;
    // On a tie the port that did not go last wins.
    grant_port   = (m0_req && m1_req) ? ~last_owner_q : m1_req;

    case (state_q)
      ST_IDLE: begin
        if (!ctl_busy && (m0_req || m1_req)) begin
          owner_d = grant_port;
          we_d    = grant_port ? m1_we    : m0_we;
          addr_d  = grant_port ? m1_addr  : m0_addr;
          wdata_d = grant_port ? m1_wdata : m0_wdata;
          wr_d    = we_d;
          rd_d    = ~we_d;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_cnt_d = '0;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Busy may not be up yet, but an early read-valid is still honoured.
        if (!we_q && ctl_valid) done = 1'b1;
        else state_d = we_q ? ST_WAIT_WR : ST_WAIT_RD;
      end
      ST_WAIT_WR: if (!ctl_busy) done = 1'b1;
      ST_WAIT_RD: if (ctl_valid) done = 1'b1;
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + 3'd1;
        if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_SETTLE || state_q == ST_WAIT_WR || state_q == ST_WAIT_RD) && !done) begin
      if (tmo_cnt_q == TMO_LIM) abort = 1'b1;
      else tmo_cnt_d = tmo_cnt_q + 8'd1;
    end

    if (done || abort) begin
      if (abort) ret_data = DATA_W'(ABORT_WORD);
      if (owner_q) begin
        m1_ack_d = 1'b1;
        if (!we_q) m1_rdata_d = ret_data;
      end else begin
        m0_ack_d = 1'b1;
        if (!we_q) m0_rdata_d = ret_data;
      end
      if (abort) tmo_d = 1'b1;
      last_owner_d = owner_q;
      gap_cnt_d    = '0;
      state_d      = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
    end
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      tmo_q        <= 1'b0;
      tmo_cnt_q    <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      tmo_q        <= tmo_d;
      tmo_cnt_q    <= tmo_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign ctl_addr  = addr_q;
  assign ctl_wdata = wdata_q;
  assign ctl_wr    = wr_q;
  assign ctl_rd    = rd_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign owner     = owner_q;
  assign tmo_err   = tmo_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: behavioural sram_controller, timeline-level
// arbiter model compared every cycle, plus directed literal checks.
module tb_sram_req_arbiter;

  localparam int TMO = 255;
  localparam int GAP = 2;

  logic        clk_50 = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic [15:0] ctl_addr, ctl_wdata, ctl_rdata;
  logic        ctl_wr, ctl_rd, ctl_valid, ctl_busy;
  logic        owner, tmo_err;

  logic        busy_i, force_busy, no_valid;
  assign ctl_busy = busy_i | force_busy;

  int n_tests = 0;
  int n_fail  = 0;

  sram_req_arbiter #(.ADDR_W(16), .DATA_W(16), .TMO_CYC(TMO), .GAP_CYC(GAP)) dut (
    .clk_50(clk_50), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .ctl_wr(ctl_wr), .ctl_rd(ctl_rd),
    .ctl_rdata(ctl_rdata), .ctl_valid(ctl_valid), .ctl_busy(ctl_busy),
    .owner(owner), .tmo_err(tmo_err)
  );

  always #10 clk_50 = ~clk_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural sram_controller ----------------
  logic [15:0] mem [0:255];
  initial begin
    int left;
    logic strobe_prev, prev_rd, op_rd;
    logic [15:0] prev_addr, prev_wdata, cap_addr;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    busy_i = 0; ctl_valid = 0; ctl_rdata = 0; left = 0;
    strobe_prev = 0; prev_rd = 0; op_rd = 0; prev_addr = 0; prev_wdata = 0; cap_addr = 0;
    forever begin
      @(posedge clk_50); #1;
      ctl_valid = 0;
      if (!rst_n) begin
        left = 0; busy_i = 0; strobe_prev = 0;
      end else begin
        if (strobe_prev) begin
          busy_i = 1; left = 3; op_rd = prev_rd; cap_addr = prev_addr;
          if (!prev_rd) mem[prev_addr[7:0]] = prev_wdata;
        end else if (left > 0) begin
          left--;
          if (left == 0) begin
            busy_i = 0;
            if (op_rd && !no_valid) begin
              ctl_valid = 1;
              ctl_rdata = mem[cap_addr[7:0]];
            end
          end
        end
        strobe_prev = ctl_wr | ctl_rd;
        prev_rd     = ctl_rd;
        prev_addr   = ctl_addr;
        prev_wdata  = ctl_wdata;
      end
    end
  end

  // ---------------- arbiter model + per-cycle compare ----------------
  // The model works on a timeline of clock edges: a grant at edge g puts the
  // strobe in the following cycle, completion is the first qualifying edge,
  // and the next grant may not happen before completion + GAP + 1.
  int          e_next = 0, m_g = 0, m_free = 0;
  bit          m_active, m_last, m_port, m_we;
  logic        exp_ack0, exp_ack1, exp_wr, exp_rd, exp_owner, exp_tmo;
  logic [15:0] exp_addr, exp_wdata, exp_rd0, exp_rd1;
  int          wr_cnt = 0, rd_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, inflight = 0, overlap = 0;
  int          grant_log[$];

  initial begin
    bit fin, ab;
    forever begin
      @(negedge clk_50);
      if (!rst_n) begin
        m_active = 0; m_last = 1; m_free = 0; inflight = 0;
        exp_ack0 = 0; exp_ack1 = 0; exp_wr = 0; exp_rd = 0; exp_owner = 0; exp_tmo = 0;
        exp_addr = 0; exp_wdata = 0; exp_rd0 = 0; exp_rd1 = 0;
      end
      check("m0_ack", m0_ack, exp_ack0);
      check("m1_ack", m1_ack, exp_ack1);
      check("m0_rdata", m0_rdata, exp_rd0);
      check("m1_rdata", m1_rdata, exp_rd1);
      check("ctl_wr", ctl_wr, exp_wr);
      check("ctl_rd", ctl_rd, exp_rd);
      check("ctl_addr", ctl_addr, exp_addr);
      check("ctl_wdata", ctl_wdata, exp_wdata);
      check("owner", owner, exp_owner);
      check("tmo_err", tmo_err, exp_tmo);

      if (ctl_wr || ctl_rd) begin
        grant_log.push_back(int'(owner));
        inflight++;
        if (inflight > 1) overlap++;
      end
      if (ctl_wr) wr_cnt++;
      if (ctl_rd) rd_cnt++;
      if (m0_ack) begin ack0_cnt++; inflight--; end
      if (m1_ack) begin ack1_cnt++; inflight--; end

      if (rst_n) begin
        exp_ack0 = 0; exp_ack1 = 0; exp_wr = 0; exp_rd = 0;
        if (m_active) begin
          if (m_we) fin = (e_next >= m_g + 3) && !ctl_busy;
          else      fin = (e_next >= m_g + 2) && ctl_valid;
          ab = !fin && (e_next == m_g + TMO + 2);
          if (fin || ab) begin
            if (m_port) exp_ack1 = 1; else exp_ack0 = 1;
            if (!m_we) begin
              if (m_port) exp_rd1 = fin ? ctl_rdata : 16'hDEAD;
              else        exp_rd0 = fin ? ctl_rdata : 16'hDEAD;
            end
            if (ab) exp_tmo = 1;
            m_active = 0;
            m_last   = m_port;
            m_free   = e_next + GAP + 1;
          end
        end else if (e_next >= m_free && !ctl_busy && (m0_req || m1_req)) begin
          m_port    = (m0_req && m1_req) ? !m_last : m1_req;
          m_we      = m_port ? m1_we : m0_we;
          exp_addr  = m_port ? m1_addr : m0_addr;
          exp_wdata = m_port ? m1_wdata : m0_wdata;
          exp_owner = m_port;
          exp_wr    = m_we;
          exp_rd    = !m_we;
          m_g       = e_next;
          m_active  = 1;
        end
      end
      e_next++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_req(input bit p, input bit r, input bit we, input logic [15:0] a, input logic [15:0] d);
    if (p) begin m1_req = r; m1_we = we; m1_addr = a; m1_wdata = d; end
    else   begin m0_req = r; m0_we = we; m0_addr = a; m0_wdata = d; end
  endtask

  task automatic wait_strobe(output int lat, output logic [15:0] sa, output logic so, output logic sw);
    bit found = 0;
    lat = 0; sa = 0; so = 0; sw = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk_50);
      lat++;
      if (ctl_wr || ctl_rd) begin found = 1; sa = ctl_addr; so = owner; sw = ctl_wr; end
    end
    if (!found) check("strobe_wait_expired", 0, 1);
  endtask

  task automatic wait_ack(input bit p, input int lim, output int lat, output logic [15:0] rd);
    bit found = 0;
    lat = 0; rd = 0;
    for (int i = 0; i < lim && !found; i++) begin
      @(negedge clk_50);
      lat++;
      if (p ? m1_ack : m0_ack) begin found = 1; rd = p ? m1_rdata : m0_rdata; end
    end
    if (!found) check("ack_wait_expired", 0, 1);
  endtask

  task automatic run_txn(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d,
                         input int ack_lat, output logic [15:0] rd);
    int lat, s_wr, s_rd, a_own, a_oth;
    logic [15:0] sa; logic so, sw;
    s_wr = wr_cnt; s_rd = rd_cnt;
    a_own = p ? ack1_cnt : ack0_cnt; a_oth = p ? ack0_cnt : ack1_cnt;
    @(posedge clk_50); #2;
    set_req(p, 1, we, a, d);
    wait_strobe(lat, sa, so, sw);
    check("req_to_strobe", lat, 2);
    check("strobe_addr", sa, a);
    check("strobe_owner", so, p);
    check("strobe_is_wr", sw, we);
    wait_ack(p, ack_lat + 20, lat, rd);
    check("strobe_to_ack", lat, ack_lat);
    @(posedge clk_50); #2;
    set_req(p, 0, we, a, d);
    repeat (4) @(posedge clk_50);
    check("wr_strobes", wr_cnt - s_wr, we ? 1 : 0);
    check("rd_strobes", rd_cnt - s_rd, we ? 0 : 1);
    check("own_acks", (p ? ack1_cnt : ack0_cnt) - a_own, 1);
    check("other_acks", (p ? ack0_cnt : ack1_cnt) - a_oth, 0);
    $display("[TB] txn port=%0d we=%0d addr=%h wdata=%h rdata=%h", p, we, a, d, rd);
  endtask

  initial begin
    logic [15:0] rd, sa;
    logic so, sw;
    int lat, base, s0;
    rst_n = 0; force_busy = 0; no_valid = 0;
    set_req(0, 0, 0, 16'h0, 16'h0);
    set_req(1, 0, 0, 16'h0, 16'h0);
    repeat (3) @(posedge clk_50);
    #2 rst_n = 1;
    @(negedge clk_50);
    check("reset_owner", owner, 0);
    check("reset_tmo", tmo_err, 0);
    check("reset_strobe", {ctl_wr, ctl_rd}, 0);
    repeat (2) @(posedge clk_50);

    run_txn(0, 1, 16'hFF11, 16'hFFAA, 5, rd);
    run_txn(0, 0, 16'hFF11, 16'h0000, 5, rd);
    check("m0_read_back", rd, 16'hFFAA);
    run_txn(1, 1, 16'h0042, 16'h1234, 5, rd);
    run_txn(1, 0, 16'h0042, 16'h0000, 5, rd);
    check("m1_read_back", rd, 16'h1234);
    check("m0_rdata_held", m0_rdata, 16'hFFAA);

    // Both ports hold requests: grants must alternate starting with port 0.
    base = grant_log.size();
    @(posedge clk_50); #2;
    set_req(0, 1, 1, 16'h000A, 16'hA0A0);
    set_req(1, 1, 1, 16'h000B, 16'hB0B0);
    for (int i = 0; i < 200 && grant_log.size() < base + 4; i++) @(negedge clk_50);
    check("rr_grants_seen", grant_log.size() - base, 4);
    @(posedge clk_50); #2;
    set_req(0, 0, 1, 16'h000A, 16'hA0A0);
    set_req(1, 0, 1, 16'h000B, 16'hB0B0);
    repeat (20) @(posedge clk_50);
    for (int k = 0; k < 4; k++) begin
      check("rr_order", (grant_log.size() > base + k) ? grant_log[base + k] : -1, k % 2);
      $display("[TB] rr grant %0d -> port %0d", k, (grant_log.size() > base + k) ? grant_log[base + k] : -1);
    end
    check("rr_total_grants", grant_log.size() - base, 4);
    check("no_overlap", overlap, 0);

    // Controller busy at request time: nothing issues until busy drops.
    @(posedge clk_50); #2;
    force_busy = 1;
    set_req(0, 1, 1, 16'h0077, 16'h5A5A);
    s0 = wr_cnt;
    repeat (8) @(negedge clk_50);
    check("busy_no_strobe", wr_cnt - s0, 0);
    @(posedge clk_50); #2;
    force_busy = 0;
    wait_strobe(lat, sa, so, sw);
    check("busy_drop_to_strobe", lat, 2);
    check("busy_strobe_addr", sa, 16'h0077);
    wait_ack(0, 40, lat, rd);
    @(posedge clk_50); #2;
    set_req(0, 0, 1, 16'h0077, 16'h5A5A);
    repeat (4) @(posedge clk_50);
    $display("[TB] busy-held write done, strobe after busy drop in %0d cycles", 2);

    // Read that never gets valid: abort after the timeout.
    no_valid = 1;
    run_txn(1, 0, 16'h0042, 16'h0000, TMO + 2, rd);
    check("tmo_rdata", rd, 16'hDEAD);
    check("tmo_sticky", tmo_err, 1);
    no_valid = 0;
    run_txn(0, 1, 16'h0033, 16'h3333, 5, rd);
    check("tmo_still_set", tmo_err, 1);

    // Reset in the middle of a read wait.
    @(posedge clk_50); #2;
    set_req(0, 1, 0, 16'hFF11, 16'h0000);
    wait_strobe(lat, sa, so, sw);
    repeat (2) @(posedge clk_50);
    #2 rst_n = 0;
    set_req(0, 0, 0, 16'hFF11, 16'h0000);
    @(negedge clk_50);
    check("rst_tmo_clear", tmo_err, 0);
    check("rst_addr", ctl_addr, 0);
    check("rst_rdata1", m1_rdata, 0);
    repeat (3) @(posedge clk_50);
    #2 rst_n = 1;
    repeat (2) @(posedge clk_50);
    $display("[TB] reset during read wait applied and released");
    run_txn(1, 0, 16'hFF11, 16'h0000, 5, rd);
    check("post_rst_read", rd, 16'hFFAA);

    repeat (4) @(posedge clk_50);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
